// File: rtl/stepper_pkg.sv
// Stepper sequencer shared definitions.
//   - state_t      : sequencer FSM state encoding
//   - PULSE_CYCLES_DEF / DIR_SETUP_CYCLES_DEF : default timing (clk_100mhz cycles)
//   - POS_W / CNT_W: absolute position and step-count widths
//   - abs_steps()  : magnitude of a signed relative move (-32768 -> 32768)
package stepper_pkg;

  localparam int PULSE_CYCLES_DEF     = 200;  // 2 us STEP high time
  localparam int DIR_SETUP_CYCLES_DEF = 100;  // 1 us DIR-to-STEP setup
  localparam int POS_W                = 32;
  localparam int CNT_W                = 16;

  typedef enum logic [2:0] {
    S_IDLE      = 3'd0,
    S_DIR_SETUP = 3'd1,
    S_WAIT_TICK = 3'd2,
    S_PULSE     = 3'd3,
    S_DONE      = 3'd4
  } state_t;

  // Unsigned magnitude; the most negative value maps to 2^(CNT_W-1),
  // which still fits because the result is unsigned.
  function automatic logic [CNT_W-1:0] abs_steps(input logic [CNT_W-1:0] v);
    return v[CNT_W-1] ? (~v + 1'b1) : v;
  endfunction

endpackage

// File: rtl/stepper_sequencer_sync_2ff.sv
// Two-flop level synchronizer for an asynchronous input.
//   clk_100mhz : destination clock
//   rst        : synchronous active-high reset, clears both flops
//   d_i        : asynchronous input
//   q_o        : synchronized output (two-cycle latency)
module sync_2ff (
  input  logic clk_100mhz,
  input  logic rst,
  input  logic d_i,
  output logic q_o
);

  logic meta_q;
  logic sync_q;

  always_ff @(posedge clk_100mhz) begin
    if (rst) begin
      meta_q <= 1'b0;
      sync_q <= 1'b0;
    end else begin
      meta_q <= d_i;
      sync_q <= meta_q;
    end
  end

  assign q_o = sync_q;

endmodule

// File: rtl/stepper_sequencer.sv
// Stepper motor STEP/DIR sequencer. Accepts signed relative moves, sets
// DIR, waits the DIR setup time, then issues one fixed-width STEP pulse per
// step-rate tick until the move completes, is aborted, or the end-stop trips.
//
// Ports:
//   clk_100mhz, rst          : clock, synchronous active-high reset
//   enable_step              : one-cycle step-rate tick
//   cmd_valid/cmd_ready      : move handshake, cmd_steps = signed relative move
//   abort                    : stop the current move
//   limit                    : asynchronous end-stop switch
//   step_out, dir_out        : driver STEP and DIR (1 = positive)
//   busy, done               : move in progress, one-cycle completion pulse
//   limit_hit                : sticky end-stop flag, cleared by next nonzero move
//   position                 : signed absolute step count (wraps)
//   steps_remaining          : steps still to issue in the current move
//
// state     | meaning
// ----------+-------------------------------------------------------------
// IDLE      | ready for a command
// DIR_SETUP | DIR driven, waiting DIR_SETUP_CYCLES before first STEP
// WAIT_TICK | waiting for enable_step, abort or end-stop
// PULSE     | STEP high for PULSE_CYCLES
// DONE      | one-cycle done pulse, then back to IDLE
module stepper_sequencer
  import stepper_pkg::*;
#(
  parameter int PULSE_CYCLES     = PULSE_CYCLES_DEF,
  parameter int DIR_SETUP_CYCLES = DIR_SETUP_CYCLES_DEF
) (
  input  logic                    clk_100mhz,
  input  logic                    rst,
  input  logic                    enable_step,
  input  logic                    cmd_valid,
  output logic                    cmd_ready,
  input  logic signed [CNT_W-1:0] cmd_steps,
  input  logic                    abort,
  input  logic                    limit,
  output logic                    step_out,
  output logic                    dir_out,
  output logic                    busy,
  output logic                    done,
  output logic                    limit_hit,
  output logic signed [POS_W-1:0] position,
  output logic        [CNT_W-1:0] steps_remaining
);

  localparam int TMR_MAX = (PULSE_CYCLES > DIR_SETUP_CYCLES) ? PULSE_CYCLES : DIR_SETUP_CYCLES;
  localparam int TMR_W   = $clog2(TMR_MAX + 1);

  // Down-counter loads: the state exits on the cycle the counter reads zero.
  localparam logic [TMR_W-1:0] SETUP_LOAD =
      TMR_W'((DIR_SETUP_CYCLES == 0) ? 0 : DIR_SETUP_CYCLES - 1);
  localparam logic [TMR_W-1:0] PULSE_LOAD = TMR_W'(PULSE_CYCLES - 1);

  state_t                    state_q;
  logic [TMR_W-1:0]          tmr_q;
  logic                      step_q;
  logic                      dir_q;
  logic                      busy_q;
  logic                      done_q;
  logic                      limit_hit_q;
  logic                      abort_pend_q;
  logic signed [POS_W-1:0]   pos_q;
  logic [CNT_W-1:0]          rem_q;
  logic                      limit_s;

  sync_2ff u_limit_sync (
    .clk_100mhz (clk_100mhz),
    .rst        (rst),
    .d_i        (limit),
    .q_o        (limit_s)
  );

  always_ff @(posedge clk_100mhz) begin
    if (rst) begin
      state_q      <= S_IDLE;
      tmr_q        <= '0;
      step_q       <= 1'b0;
      dir_q        <= 1'b0;
      busy_q       <= 1'b0;
      done_q       <= 1'b0;
      limit_hit_q  <= 1'b0;
      abort_pend_q <= 1'b0;
      pos_q        <= '0;
      rem_q        <= '0;
    end else begin
      done_q <= 1'b0;
      case (state_q)
        S_IDLE: begin
          if (cmd_valid) begin
            rem_q <= abs_steps(cmd_steps);
            if (cmd_steps == '0) begin
              // Null move: complete immediately, DIR untouched.
              state_q <= S_DONE;
              done_q  <= 1'b1;
            end else begin
              dir_q        <= ~cmd_steps[CNT_W-1];
              limit_hit_q  <= 1'b0;
              busy_q       <= 1'b1;
              abort_pend_q <= 1'b0;
              tmr_q        <= SETUP_LOAD;
              state_q      <= S_DIR_SETUP;
            end
          end
        end

        S_DIR_SETUP: begin
          if (abort) begin
            state_q <= S_DONE;
            done_q  <= 1'b1;
          end else if (tmr_q == '0) begin
            state_q <= S_WAIT_TICK;
          end else begin
            tmr_q <= tmr_q - 1'b1;
          end
        end

        S_WAIT_TICK: begin
          // Abort and end-stop take priority over a coincident tick.
          if (abort || limit_s) begin
            if (limit_s) limit_hit_q <= 1'b1;
            state_q <= S_DONE;
            done_q  <= 1'b1;
          end else if (enable_step) begin
            step_q  <= 1'b1;
            tmr_q   <= PULSE_LOAD;
            pos_q   <= dir_q ? (pos_q + 32'sd1) : (pos_q - 32'sd1);
            rem_q   <= rem_q - 1'b1;
            state_q <= S_PULSE;
          end
        end

        S_PULSE: begin
          // An abort here is remembered so the pulse still completes at full width.
          if (abort) abort_pend_q <= 1'b1;
          if (tmr_q == '0) begin
            step_q <= 1'b0;
            if (rem_q == '0 || abort_pend_q || abort) begin
              state_q <= S_DONE;
              done_q  <= 1'b1;
            end else begin
              state_q <= S_WAIT_TICK;
            end
          end else begin
            tmr_q <= tmr_q - 1'b1;
          end
        end

        S_DONE: begin
          busy_q       <= 1'b0;
          abort_pend_q <= 1'b0;
          state_q      <= S_IDLE;
        end

        default: begin
          step_q  <= 1'b0;
          busy_q  <= 1'b0;
          state_q <= S_IDLE;
        end
      endcase
    end
  end

  assign cmd_ready       = (state_q == S_IDLE) && !rst;
  assign step_out        = step_q;
  assign dir_out         = dir_q;
  assign busy            = busy_q;
  assign done            = done_q;
  assign limit_hit       = limit_hit_q;
  assign position        = pos_q;
  assign steps_remaining = rem_q;

endmodule

// File: tb/tb_stepper_sequencer.sv
module tb_stepper_sequencer;

  logic               clk_100mhz = 1'b0;
  logic               rst = 1'b1;
  logic               enable_step = 1'b0;
  logic               cmd_valid = 1'b0;
  logic               cmd_ready;
  logic signed [15:0] cmd_steps = '0;
  logic               abort = 1'b0;
  logic               limit = 1'b0;
  logic               step_out;
  logic               dir_out;
  logic               busy;
  logic               done;
  logic               limit_hit;
  logic signed [31:0] position;
  logic        [15:0] steps_remaining;

  stepper_sequencer #(.PULSE_CYCLES(4), .DIR_SETUP_CYCLES(3)) dut (
    .clk_100mhz      (clk_100mhz),
    .rst             (rst),
    .enable_step     (enable_step),
    .cmd_valid       (cmd_valid),
    .cmd_ready       (cmd_ready),
    .cmd_steps       (cmd_steps),
    .abort           (abort),
    .limit           (limit),
    .step_out        (step_out),
    .dir_out         (dir_out),
    .busy            (busy),
    .done            (done),
    .limit_hit       (limit_hit),
    .position        (position),
    .steps_remaining (steps_remaining)
  );

  always #5 clk_100mhz = ~clk_100mhz;

  int n_asserts = 0;
  int n_fails   = 0;

  // per-move observations
  int tick_ctr = 0;
  int rise_cnt, done_cnt, bad_w, misalign, cur_w;
  logic busy_seen, step_prev, en_at_edge, timeout;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_asserts++;
    assert (obs === exp) else begin
      n_fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic clr_stats();
    rise_cnt = 0; done_cnt = 0; bad_w = 0; misalign = 0; cur_w = 0;
    busy_seen = 1'b0; step_prev = step_out; timeout = 1'b0;
  endtask

  // One clock: sample outputs 1 time unit after the edge, then set up the
  // tick for the next edge (one tick every 20 cycles).
  task automatic cyc();
    @(posedge clk_100mhz);
    #1;
    en_at_edge = enable_step;
    if (step_out && !step_prev) begin
      rise_cnt++;
      if (!en_at_edge) misalign++;
    end
    if (step_out) cur_w++;
    else if (step_prev) begin
      if (cur_w != 4) bad_w++;
      cur_w = 0;
    end
    step_prev = step_out;
    if (done) done_cnt++;
    if (busy) busy_seen = 1'b1;
    tick_ctr = (tick_ctr == 19) ? 0 : tick_ctr + 1;
    enable_step = (tick_ctr == 19);
  endtask

  task automatic accept(input logic signed [15:0] v);
    cmd_steps = v;
    cmd_valid = 1'b1;
    cyc();
    cmd_valid = 1'b0;
  endtask

  task automatic run_to_idle(input int budget);
    logic seen;
    seen = 1'b0;
    timeout = 1'b1;
    for (int i = 0; i < budget; i++) begin
      cyc();
      if (done) seen = 1'b1;
      if (seen && cmd_ready) begin timeout = 1'b0; break; end
    end
  endtask

  task automatic wait_rise(input int n, input int budget);
    timeout = 1'b1;
    for (int i = 0; i < budget; i++) begin
      if (rise_cnt >= n) begin timeout = 1'b0; break; end
      cyc();
    end
  endtask

  initial begin
    // ---- reset state
    rst = 1'b1;
    repeat (3) cyc();
    chk("rst_cmd_ready", cmd_ready, 0);
    chk("rst_step", step_out, 0);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_pos", position, 0);
    chk("rst_rem", steps_remaining, 0);
    rst = 1'b0;
    #1;
    chk("idle_ready", cmd_ready, 1);
    cyc();

    // ---- +3
    clr_stats();
    accept(16'sd3);
    chk("p3_dir", dir_out, 1);
    chk("p3_rem_acc", steps_remaining, 3);
    chk("p3_busy", busy, 1);
    run_to_idle(200);
    chk("p3_timeout", timeout, 0);
    chk("p3_pulses", rise_cnt, 3);
    chk("p3_width", bad_w, 0);
    chk("p3_align", misalign, 0);
    chk("p3_pos", position, 3);
    chk("p3_done_cnt", done_cnt, 1);
    chk("p3_busy_end", busy, 0);

    // ---- 0 (DIR must stay 1)
    clr_stats();
    accept(16'sd0);
    chk("z_done", done, 1);
    chk("z_ready_done", cmd_ready, 0);
    cyc();
    chk("z_done_off", done, 0);
    chk("z_ready", cmd_ready, 1);
    repeat (25) cyc();
    chk("z_pulses", rise_cnt, 0);
    chk("z_busy_seen", busy_seen, 0);
    chk("z_dir", dir_out, 1);
    chk("z_done_cnt", done_cnt, 1);

    // ---- -2 from 3, with a tick landing in DIR_SETUP
    clr_stats();
    tick_ctr = 18;
    accept(-16'sd2);
    chk("m2_dir", dir_out, 0);
    repeat (3) cyc();
    chk("m2_setup_nopulse", rise_cnt, 0);
    run_to_idle(200);
    chk("m2_timeout", timeout, 0);
    chk("m2_pulses", rise_cnt, 2);
    chk("m2_width", bad_w, 0);
    chk("m2_pos", position, 1);
    chk("m2_rem", steps_remaining, 0);
    chk("m2_done_cnt", done_cnt, 1);

    // ---- +5 with abort 2 cycles into the 2nd pulse
    clr_stats();
    accept(16'sd5);
    wait_rise(2, 200);
    chk("ab_wait_timeout", timeout, 0);
    cyc();
    abort = 1'b1;
    cyc();
    abort = 1'b0;
    run_to_idle(200);
    chk("ab_timeout", timeout, 0);
    chk("ab_pulses", rise_cnt, 2);
    chk("ab_width", bad_w, 0);
    chk("ab_pos", position, 3);
    chk("ab_rem", steps_remaining, 3);
    chk("ab_done_cnt", done_cnt, 1);

    // ---- +10 with limit after 4 steps
    clr_stats();
    accept(16'sd10);
    chk("lim_clear_acc", limit_hit, 0);
    wait_rise(4, 400);
    chk("lim_wait_timeout", timeout, 0);
    for (int i = 0; i < 10 && step_out; i++) cyc();
    limit = 1'b1;
    run_to_idle(200);
    chk("lim_timeout", timeout, 0);
    chk("lim_hit", limit_hit, 1);
    chk("lim_pulses", rise_cnt, 4);
    chk("lim_pos", position, 7);
    chk("lim_rem", steps_remaining, 6);
    chk("lim_done_cnt", done_cnt, 1);
    limit = 1'b0;
    repeat (4) cyc();

    // ---- -32768, then reset mid-pulse
    clr_stats();
    accept(-16'sd32768);
    chk("big_rem", steps_remaining, 32768);
    chk("big_dir", dir_out, 0);
    chk("big_lim_clr", limit_hit, 0);
    wait_rise(1, 100);
    chk("big_wait_timeout", timeout, 0);
    chk("big_pos", position, 6);
    chk("big_rem_dec", steps_remaining, 32767);
    rst = 1'b1;
    done_cnt = 0;
    cyc();
    chk("mid_rst_step", step_out, 0);
    chk("mid_rst_dir", dir_out, 0);
    chk("mid_rst_busy", busy, 0);
    chk("mid_rst_pos", position, 0);
    chk("mid_rst_rem", steps_remaining, 0);
    chk("mid_rst_ready", cmd_ready, 0);
    rst = 1'b0;
    repeat (5) cyc();
    chk("mid_rst_no_done", done_cnt, 0);
    chk("post_rst_ready", cmd_ready, 1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_asserts, n_fails);
    $finish;
  end

endmodule
